mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller. Sits in the EXE stage beside the ALU and owns the HI/LO registers.
- Sequences a 32-iteration shift-add multiplier and restoring divider.
- Generates the pipeline stall for HI/LO hazards and for the GPR-writing MUL instruction.
- Drives MDU_out, which feeds the writeback and forwarding muxes.

Parameters:
- XLEN, 32, operand/result width.
- ITER, 32, iterations per mul/div; must equal XLEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  valid instruction in EXE.
- ex_op  in  3  000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 MUL.
- ex_rd_hilo  in  1  EXE instruction is MFHI/MFLO.
- ex_rd_hi  in  1  1 = MFHI, 0 = MFLO.
- rs_value  in  32  forwarded rs operand.
- rt_value  in  32  forwarded rt operand.
- flush  in  1  kill the EXE instruction this cycle.
- stall  out  1  hold IF/ID/EXE (combinational).
- busy  out  1  state != IDLE (registered state).
- hi  out  32  HI register.
- lo  out  32  LO register.
- mdu_out  out  32  MFHI → hi; MFLO → lo; MUL in DONE → lo; else 0.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low. On reset: state = IDLE, hi = lo = 0, counter = 0, internal operand/accumulator registers = 0, busy = 0.
- States:
  - IDLE: no operation in progress.
  - CALC: one iteration per edge, counter 0..31.
  - FIN: sign fix-up and HI/LO write.
  - DONE: MUL only; hands the result to the pipeline.
- Accept: edge where state == IDLE, ex_valid, !flush, ex_op ∈ {MULT, MULTU, DIV, DIVU, MUL}.
  - Latches operands, clears counter, goes to CALC.
  - Signed ops latch magnitudes plus sign flags.
- CALC → FIN on the edge completing iteration 31.
- FIN:
  - Writes hi/lo.
  - MUL → DONE; everything else → IDLE.
  - HI/LO are visible at accept edge + 33.
- DONE → IDLE unconditionally on the next edge. No accept in DONE, because the same MUL is still in EXE.
- Stall (combinational):
  - ex_valid && !flush, and any of:
    - ex_op ∈ {MULT, MULTU, DIV, DIVU, MTHI, MTLO} && state ∈ {CALC, FIN};
    - ex_rd_hilo && state ∈ {CALC, FIN};
    - ex_op == MUL && state != DONE.
  - MULT/DIV accepted in IDLE do not stall; the pipeline continues.
  - DONE never stalls.
- MTHI/MTLO: write rs_value to hi/lo on an edge where state == IDLE, ex_valid, !flush.
- Multiply: 64-bit unsigned product of magnitudes; negate the 64-bit result when signs differ (MULT/MUL only); HI = [63:32], LO = [31:0].
- Divide:
  - Restoring division on magnitudes.
  - Signed quotient is negated when signs differ; remainder takes the dividend's sign.
  - Divisor 0 (all div ops): LO = 0xFFFFFFFF, HI = rs_value as latched.
- Flush:
  - Suppresses accept and MTHI/MTLO that cycle.
  - While state ∈ {CALC, FIN} for a MUL: abort to IDLE, hi/lo unchanged.
  - MULT/DIV in progress ignore flush; their instruction has already left EXE.
  - In DONE: go to IDLE.
- Overflow: INT_MIN / -1 yields LO = 0x80000000, HI = 0 (natural wrap).
- Reset mid-operation: immediate IDLE; hi = lo = 0.

Decomposition:
- Shared package mdu_pkg:
  - ex_op encodings (MDU_NONE .. MDU_MUL);
  - state encoding (IDLE, CALC, FIN, DONE);
  - ITER_LAST = 31.
- One natural sub-module, mdu_iter_core:
  - shift/add and compare/subtract datapath with a mode input;
  - one iteration per enable;
  - controlled by mdu_ctrl's FSM and counter.

Test Plan:
- MULT rs = 0xFFFFFFFD (−3), rt = 7, accept at edge E → busy = 1 from E; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB at E+33; stall never asserted.
- DIV rs = 0xFFFFFFF9 (−7), rt = 2, then MFLO issued 3 cycles later → stall high until state leaves FIN; mdu_out = lo = 0xFFFFFFFD; hi = 0xFFFFFFFF.
- DIVU rs = 0x12345678, rt = 0 → lo = 0xFFFFFFFF, hi = 0x12345678 at E+33.
- MUL rs = 0x00010000, rt = 0x00010000 → stall for 34 cycles (accept through FIN); DONE cycle: stall = 0, mdu_out = 0; hi = 1, lo = 0; IDLE next edge.
- MUL with flush at CALC iteration 10 → state IDLE next edge; hi/lo retain prior values; stall drops.
- MTHI rs = 0xA5A5A5A5 in IDLE, then MFHI → hi = 0xA5A5A5A5, mdu_out = 0xA5A5A5A5, no stall. Then rst_n low during a MULT CALC → asynchronously state = IDLE, hi = lo = 0, busy = 0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcode and state encodings,
// iteration bound and small opcode classification helpers.
package mdu_pkg;

  localparam int ITER_LAST = 31;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'b000,
    MDU_MULT  = 3'b001,
    MDU_MULTU = 3'b010,
    MDU_DIV   = 3'b011,
    MDU_DIVU  = 3'b100,
    MDU_MTHI  = 3'b101,
    MDU_MTLO  = 3'b110,
    MDU_MUL   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIN  = 2'b10,
    S_DONE = 2'b11
  } mdu_state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mdu_mode_e;

  // Operations that run the 32-iteration datapath.
  function automatic logic is_iter_op(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) ||
           (op == MDU_DIVU) || (op == MDU_MUL);
  endfunction

  // Operations whose operands are two's-complement.
  function automatic logic is_signed_op(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MUL);
  endfunction

  function automatic logic is_div_op(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// EXE-stage <-> MDU signal bundle. The pipeline is the master, the MDU the slave.
interface mdu_if #(parameter int XLEN = 32);

  logic            ex_valid;
  logic [2:0]      ex_op;
  logic            ex_rd_hilo;
  logic            ex_rd_hi;
  logic [XLEN-1:0] rs_value;
  logic [XLEN-1:0] rt_value;
  logic            flush;

  logic            stall;
  logic            busy;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] mdu_out;

  modport master (
    output ex_valid, ex_op, ex_rd_hilo, ex_rd_hi, rs_value, rt_value, flush,
    input  stall, busy, hi, lo, mdu_out
  );

  modport slave (
    input  ex_valid, ex_op, ex_rd_hilo, ex_rd_hi, rs_value, rt_value, flush,
    output stall, busy, hi, lo, mdu_out
  );

endinterface

// File: rtl/mdu_iter_core.sv
// One-bit-per-step datapath shared by the shift-add multiplier and the
// restoring divider. Operates on magnitudes only; sign handling is done by
// the controller. After ITER steps:
//   multiply: {acc, q} = m * q_initial
//   divide  : q = quotient, acc = remainder of q_initial / m
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            en,
  input  mdu_mode_e       mode,
  input  logic [XLEN-1:0] load_q,
  input  logic [XLEN-1:0] load_m,
  output logic [XLEN-1:0] acc,
  output logic [XLEN-1:0] q
);

  logic [XLEN-1:0] acc_reg, acc_next;
  logic [XLEN-1:0] q_reg, q_next;
  logic [XLEN-1:0] m_reg;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;

  // Single iteration step for the selected mode.
  always_comb begin
    sum      = {1'b0, acc_reg} + (q_reg[0] ? {1'b0, m_reg} : '0);
    shifted  = {acc_reg, q_reg[XLEN-1]};
    acc_next = acc_reg;
    q_next   = q_reg;
    if (mode == MODE_MUL) begin
      // Add multiplicand when the low multiplier bit is set, then shift the
      // 65-bit {carry, acc, q} right by one.
      acc_next = sum[XLEN:1];
      q_next   = {sum[0], q_reg[XLEN-1:1]};
    end else if (shifted >= {1'b0, m_reg}) begin
      // Partial remainder fits: subtract and shift in a 1. The difference is
      // always below the divisor, so the low XLEN bits are exact.
      acc_next = shifted[XLEN-1:0] - m_reg;
      q_next   = {q_reg[XLEN-2:0], 1'b1};
    end else begin
      acc_next = shifted[XLEN-1:0];
      q_next   = {q_reg[XLEN-2:0], 1'b0};
    end
  end

  // Operand load on accept, otherwise one step per enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
      q_reg   <= '0;
      m_reg   <= '0;
    end else if (load) begin
      acc_reg <= '0;
      q_reg   <= load_q;
      m_reg   <= load_m;
    end else if (en) begin
      acc_reg <= acc_next;
      q_reg   <= q_next;
    end
  end

  assign acc = acc_reg;
  assign q   = q_reg;

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the EXE stage. Owns HI/LO, sequences the
// iterative core, raises pipeline stalls for HI/LO hazards and for the
// GPR-writing MUL, and drives the MDU result onto mdu_out.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic clk,
  input  logic rst_n,
  mdu_if.slave bus
);

  localparam int                CNT_W    = $clog2(ITER);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ITER - 1);

  mdu_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  mdu_op_e          op_reg;
  logic             neg_res_reg;
  logic             neg_rem_reg;
  logic             div0_reg;
  logic [XLEN-1:0]  rs_raw_reg;
  logic [XLEN-1:0]  hi_reg, hi_next;
  logic [XLEN-1:0]  lo_reg, lo_next;

  mdu_op_e          op_in;
  logic             ex_live;
  logic             accept;
  logic             hilo_busy;
  logic             mul_abort;
  logic             fin_write;
  logic             rs_neg, rt_neg;
  logic [XLEN-1:0]  rs_mag, rt_mag;
  logic [XLEN-1:0]  core_acc, core_q;
  logic [2*XLEN-1:0] prod_mag, prod;
  logic [XLEN-1:0]  quo, rem;
  logic [XLEN-1:0]  res_hi, res_lo;

  assign op_in     = mdu_op_e'(bus.ex_op);
  assign ex_live   = bus.ex_valid && !bus.flush;
  assign accept    = (state_reg == S_IDLE) && ex_live && is_iter_op(op_in);
  assign hilo_busy = (state_reg == S_CALC) || (state_reg == S_FIN);
  // Only a MUL is still sitting in EXE while it computes, so only it can be killed.
  assign mul_abort = bus.flush && (op_reg == MDU_MUL) && hilo_busy;
  assign fin_write = (state_reg == S_FIN) && !mul_abort;

  // Operand magnitudes for signed ops.
  assign rs_neg = is_signed_op(op_in) && bus.rs_value[XLEN-1];
  assign rt_neg = is_signed_op(op_in) && bus.rt_value[XLEN-1];
  assign rs_mag = rs_neg ? -bus.rs_value : bus.rs_value;
  assign rt_mag = rt_neg ? -bus.rt_value : bus.rt_value;

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .en     (state_reg == S_CALC),
    .mode   (is_div_op(op_reg) ? MODE_DIV : MODE_MUL),
    .load_q (is_div_op(op_in) ? rs_mag : rt_mag),
    .load_m (is_div_op(op_in) ? rt_mag : rs_mag),
    .acc    (core_acc),
    .q      (core_q)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: if (accept) state_next = S_CALC;
      S_CALC: begin
        if (mul_abort)               state_next = S_IDLE;
        else if (cnt_reg == CNT_LAST) state_next = S_FIN;
      end
      S_FIN: begin
        if (mul_abort)              state_next = S_IDLE;
        else if (op_reg == MDU_MUL) state_next = S_DONE;
        else                        state_next = S_IDLE;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Iteration counter and per-operation context captured at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      op_reg      <= MDU_NONE;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      div0_reg    <= 1'b0;
      rs_raw_reg  <= '0;
    end else if (accept) begin
      cnt_reg     <= '0;
      op_reg      <= op_in;
      neg_res_reg <= rs_neg ^ rt_neg;
      neg_rem_reg <= rs_neg;
      div0_reg    <= (bus.rt_value == '0);
      rs_raw_reg  <= bus.rs_value;
    end else if (state_reg == S_CALC) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Sign fix-up of the raw core result into HI/LO values.
  always_comb begin
    prod_mag = {core_acc, core_q};
    prod     = neg_res_reg ? -prod_mag : prod_mag;
    quo      = neg_res_reg ? -core_q : core_q;
    rem      = neg_rem_reg ? -core_acc : core_acc;
    if (is_div_op(op_reg)) begin
      if (div0_reg) begin
        res_hi = rs_raw_reg;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end else begin
      res_hi = prod[2*XLEN-1:XLEN];
      res_lo = prod[XLEN-1:0];
    end
  end

  // HI/LO update: result write in FIN, or a move-to when no op is in flight.
  always_comb begin
    hi_next = hi_reg;
    lo_next = lo_reg;
    if (fin_write) begin
      hi_next = res_hi;
      lo_next = res_lo;
    end else if ((state_reg == S_IDLE) && ex_live) begin
      if (op_in == MDU_MTHI) hi_next = bus.rs_value;
      if (op_in == MDU_MTLO) lo_next = bus.rs_value;
    end
  end

  // HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else begin
      hi_reg <= hi_next;
      lo_reg <= lo_next;
    end
  end

  // Outputs: stall, busy and the result mux toward writeback/forwarding.
  always_comb begin
    bus.stall = 1'b0;
    if (ex_live) begin
      if (hilo_busy && ((is_iter_op(op_in) && (op_in != MDU_MUL)) ||
                        (op_in == MDU_MTHI) || (op_in == MDU_MTLO)))
        bus.stall = 1'b1;
      if (hilo_busy && bus.ex_rd_hilo)
        bus.stall = 1'b1;
      if ((op_in == MDU_MUL) && (state_reg != S_DONE))
        bus.stall = 1'b1;
    end
    bus.busy    = (state_reg != S_IDLE);
    bus.hi      = hi_reg;
    bus.lo      = lo_reg;
    bus.mdu_out = '0;
    if (bus.ex_valid && bus.ex_rd_hilo)
      bus.mdu_out = bus.ex_rd_hi ? hi_reg : lo_reg;
    else if (state_reg == S_DONE)
      bus.mdu_out = lo_reg;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus randomized
// operations checked against an arithmetic reference model.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mdu_if #(.XLEN(32)) bus ();

  mdu_ctrl #(.XLEN(32), .ITER(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  // Reference: {HI, LO} from plain arithmetic on the operation.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    p = '0;
    case (op)
      MDU_MULT, MDU_MUL: p = 64'(sa * sb);
      MDU_MULTU:         p = {32'd0, a} * {32'd0, b};
      MDU_DIV: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
        else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          p = {32'(r), 32'(q)};
        end
      end
      MDU_DIVU: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
      default: p = {m_hi, m_lo};
    endcase
    return p;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  task automatic idle();
    bus.ex_valid   = 1'b0;
    bus.ex_op      = MDU_NONE;
    bus.ex_rd_hilo = 1'b0;
    bus.ex_rd_hi   = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.ex_valid   = 1'b1;
    bus.ex_op      = op;
    bus.ex_rd_hilo = 1'b0;
    bus.ex_rd_hi   = 1'b0;
    bus.rs_value   = a;
    bus.rt_value   = b;
    bus.flush      = 1'b0;
  endtask

  task automatic check_hilo(input string name, input logic [63:0] exp);
    checks++;
    if ({bus.hi, bus.lo} !== exp) begin
      errors++;
      $display("FAIL %s: hi/lo got %h_%h expected %h_%h", name, bus.hi, bus.lo, exp[63:32], exp[31:0]);
    end
  endtask

  // MULT/MULTU/DIV/DIVU: no stall, busy from accept, result at accept + 33.
  task automatic run_muldiv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    exp = ref_result(op, a, b);
    @(negedge clk); drive(op, a, b); #1;
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL issue_stall: got %b expected 0", bus.stall); end
    @(negedge clk); idle(); #1;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept: got %b expected 1", bus.busy); end
    repeat (32) @(negedge clk);
    check_hilo("hilo_before_fin", {m_hi, m_lo});
    @(negedge clk); #1;
    check_hilo("hilo_result", exp);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_after_fin: got %b expected 0", bus.busy); end
    {m_hi, m_lo} = exp;
    $display("txn op=%0d rs=%h rt=%h -> hi=%h lo=%h", op, a, b, bus.hi, bus.lo);
  endtask

  // MUL: stalls accept through FIN (34 cycles), result on mdu_out in DONE.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int n;
    exp = ref_result(MDU_MUL, a, b);
    @(negedge clk); drive(MDU_MUL, a, b); #1;
    n = 0;
    while (bus.stall === 1'b1 && n < 60) begin n++; @(negedge clk); #1; end
    checks++;
    if (n != 34) begin errors++; $display("FAIL mul_stall_cycles: got %0d expected 34", n); end
    checks++;
    if (bus.mdu_out !== exp[31:0]) begin errors++; $display("FAIL mul_mdu_out: got %h expected %h", bus.mdu_out, exp[31:0]); end
    check_hilo("mul_hilo", exp);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL mul_done_busy: got %b expected 1", bus.busy); end
    idle();
    @(negedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL mul_idle_after_done: got %b expected 0", bus.busy); end
    {m_hi, m_lo} = exp;
    $display("txn op=MUL rs=%h rt=%h -> hi=%h lo=%h stall=%0d", a, b, bus.hi, bus.lo, n);
  endtask

  task automatic test_reset();
    idle();
    bus.rs_value = '0;
    bus.rt_value = '0;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.busy, bus.stall} !== 2'b00) begin errors++; $display("FAIL reset_busy_stall: got %b expected 00", {bus.busy, bus.stall}); end
    check_hilo("reset_hilo", 64'd0);
    checks++;
    if (bus.mdu_out !== 32'd0) begin errors++; $display("FAIL reset_mdu_out: got %h expected 0", bus.mdu_out); end
    @(negedge clk); rst_n = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_mult();
    run_muldiv(MDU_MULT, 32'hFFFF_FFFD, 32'd7);
  endtask

  task automatic test_div_mflo();
    logic [63:0] exp;
    int n;
    exp = ref_result(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    @(negedge clk); drive(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    bus.ex_valid = 1'b1; bus.ex_rd_hilo = 1'b1; bus.ex_rd_hi = 1'b0; #1;
    n = 0;
    while (bus.stall === 1'b1 && n < 60) begin n++; @(negedge clk); #1; end
    checks++;
    if (n != 30) begin errors++; $display("FAIL mflo_stall_cycles: got %0d expected 30", n); end
    checks++;
    if (bus.mdu_out !== exp[31:0]) begin errors++; $display("FAIL mflo_mdu_out: got %h expected %h", bus.mdu_out, exp[31:0]); end
    check_hilo("div_hilo", exp);
    {m_hi, m_lo} = exp;
    idle();
    $display("txn DIV -7/2 then MFLO -> lo=%h hi=%h stall=%0d", bus.lo, bus.hi, n);
  endtask

  task automatic test_divu_zero();
    run_muldiv(MDU_DIVU, 32'h1234_5678, 32'd0);
    run_muldiv(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_mul();
    run_mul(32'h0001_0000, 32'h0001_0000);
  endtask

  task automatic test_mul_flush();
    @(negedge clk); drive(MDU_MUL, 32'h0000_1234, 32'h0000_5678);
    @(negedge clk);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1; #1;
    checks++;
    if ({bus.stall, bus.busy} !== 2'b01) begin errors++; $display("FAIL flush_stall_busy: got %b expected 01", {bus.stall, bus.busy}); end
    @(negedge clk); idle(); #1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_abort_idle: got %b expected 0", bus.busy); end
    check_hilo("flush_hilo_kept", {m_hi, m_lo});
    repeat (25) @(negedge clk);
    check_hilo("flush_hilo_later", {m_hi, m_lo});
    $display("txn MUL flushed at iteration 10 -> hi=%h lo=%h", bus.hi, bus.lo);
  endtask

  task automatic test_mthi_mfhi();
    @(negedge clk); drive(MDU_MTHI, 32'hA5A5_A5A5, 32'd0); #1;
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL mthi_stall: got %b expected 0", bus.stall); end
    @(negedge clk);
    idle(); bus.ex_valid = 1'b1; bus.ex_rd_hilo = 1'b1; bus.ex_rd_hi = 1'b1; #1;
    m_hi = 32'hA5A5_A5A5;
    checks++;
    if ({bus.stall, bus.mdu_out} !== {1'b0, m_hi}) begin errors++; $display("FAIL mfhi_out: got stall=%b out=%h expected 0 %h", bus.stall, bus.mdu_out, m_hi); end
    check_hilo("mthi_hilo", {m_hi, m_lo});
    idle();
    $display("txn MTHI/MFHI -> hi=%h out ok", bus.hi);
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp1, exp2;
    int n;
    exp1 = ref_result(MDU_MULT, 32'hFFFF_FF00, 32'h0000_0300);
    exp2 = ref_result(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk); drive(MDU_MULT, 32'hFFFF_FF00, 32'h0000_0300);
    @(negedge clk); drive(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); #1;
    n = 0;
    while (bus.stall === 1'b1 && n < 60) begin n++; @(negedge clk); #1; end
    checks++;
    if (n != 33) begin errors++; $display("FAIL b2b_stall_cycles: got %0d expected 33", n); end
    check_hilo("b2b_first", exp1);
    @(negedge clk); idle();
    repeat (33) @(negedge clk);
    #1;
    check_hilo("b2b_second", exp2);
    {m_hi, m_lo} = exp2;
    $display("txn back-to-back MULT/MULTU -> hi=%h lo=%h", bus.hi, bus.lo);
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      a = pick_operand();
      b = pick_operand();
      op = 3'($urandom_range(1, 7));
      if (op == MDU_MUL) begin
        run_mul(a, b);
      end else if (op == MDU_MTHI || op == MDU_MTLO) begin
        @(negedge clk); drive(op, a, b);
        @(negedge clk); idle(); #1;
        if (op == MDU_MTHI) m_hi = a; else m_lo = a;
        check_hilo("rand_move", {m_hi, m_lo});
        $display("txn op=%0d rs=%h -> hi=%h lo=%h", op, a, bus.hi, bus.lo);
      end else begin
        run_muldiv(op, a, b);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk); drive(MDU_MULT, 32'h0000_0123, 32'h0000_0456);
    @(negedge clk); idle();
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b expected 0", bus.busy); end
    check_hilo("async_reset_hilo", 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %b expected 0", bus.busy); end
    $display("txn async reset mid-MULT -> busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_mflo();
    test_divu_zero();
    test_mul();
    test_mul_flush();
    test_mthi_mfhi();
    test_back_to_back();
    test_random();
    test_mthi_mfhi();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
